// File: rtl/arb_pkg.sv
// Shared constants and types for the eight-way round-robin arbiter.
// Also provides the decode used by the downstream 3-to-8 select stage.
package arb_pkg;

  localparam int NREQ  = 8;
  localparam int IDX_W = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // One-hot select as seen by the 3-to-8 decoder fed by gnt_idx/gnt_valid.
  function automatic logic [NREQ-1:0] grant_onehot(input logic [IDX_W-1:0] idx,
                                                   input logic             en);
    logic [NREQ-1:0] sel;
    sel = {NREQ{1'b0}};
    if (en) begin
      sel[idx] = 1'b1;
    end else begin
      sel = {NREQ{1'b0}};
    end
    return sel;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational rotate-priority picker: first set request at or after ptr.
// The picker is rotate right by ptr, lowest-bit priority encode, then add ptr back.
module rr_pick8
  import arb_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] win_idx,
  output logic             any
);

  logic [2*NREQ-1:0] dbl_s;
  logic [NREQ-1:0]   rot_s;
  logic [IDX_W-1:0]  enc_s;
  logic              hit_s;

  // Rotate so that requester ptr lands on bit 0, then take the lowest set bit.
  always_comb begin
    dbl_s = {req, req} >> ptr;
    rot_s = dbl_s[NREQ-1:0];
    enc_s = {IDX_W{1'b0}};
    hit_s = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      if (rot_s[j] && !hit_s) begin
        enc_s = IDX_W'(j);
        hit_s = 1'b1;
      end else begin
        hit_s = hit_s;
      end
    end
    win_idx = enc_s + ptr;
    any     = |req;
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-requester round-robin arbiter with a bounded grant hold.
// Drives a registered grant index and valid strobe into the 3-to-8 select decoder.
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             arb_en,
  input  logic [NREQ-1:0]  req,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  localparam int                 HOLD_W   = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0]  HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0]  HOLD_ONE = HOLD_W'(1);

  arb_state_t        state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [IDX_W-1:0]  gnt_idx_q, gnt_idx_d;
  logic              gnt_valid_q, gnt_valid_d;

  logic [IDX_W-1:0]  win_idx_s;
  logic              any_s;
  logic              release_s;

  rr_pick8 u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .win_idx (win_idx_s),
    .any     (any_s)
  );

  // The owner lets go when its request falls or it has used its full hold budget.
  assign release_s = !req[gnt_idx_q] || (hold_q == HOLD_MAX);

  // Next-state logic; gnt_idx only moves on a fresh grant so it is stable while valid.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hold_d      = hold_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    case (state_q)
      IDLE: begin
        if (arb_en && any_s) begin
          gnt_idx_d   = win_idx_s;
          gnt_valid_d = 1'b1;
          hold_d      = HOLD_ONE;
          state_d     = GRANT;
        end else begin
          gnt_valid_d = 1'b0;
        end
      end
      GRANT: begin
        if (release_s) begin
          gnt_valid_d = 1'b0;
          ptr_d       = gnt_idx_q + 3'd1;
          hold_d      = {HOLD_W{1'b0}};
          state_d     = IDLE;
        end else begin
          hold_d = hold_q + HOLD_ONE;
        end
      end
      default: begin
        gnt_valid_d = 1'b0;
        hold_d      = {HOLD_W{1'b0}};
        state_d     = IDLE;
      end
    endcase
  end

  // State and output registers; reset clears the grant without waiting for clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= {IDX_W{1'b0}};
      hold_q      <= {HOLD_W{1'b0}};
      gnt_idx_q   <= {IDX_W{1'b0}};
      gnt_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hold_q      <= hold_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
    end
  end

  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Scoreboard bench for rr_arbiter8 with a reduced hold limit of 4.
// A reference model queues the expected {valid, idx} for every clocked cycle.
module tb_rr_arbiter8;

  localparam int MAXH = 4;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       arb_en = 1'b0;
  logic [7:0] req    = 8'h00;
  logic [2:0] gnt_idx;
  logic       gnt_valid;

  rr_arbiter8 #(.MAX_HOLD(MAXH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .arb_en    (arb_en),
    .req       (req),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  logic [3:0] sb[$];

  logic       m_grant;
  logic       m_valid;
  logic [2:0] m_idx;
  int         m_ptr;
  int         m_hold;

  task automatic model_reset();
    m_grant = 1'b0;
    m_valid = 1'b0;
    m_idx   = 3'd0;
    m_ptr   = 0;
    m_hold  = 0;
    sb.delete();
  endtask

  // Apply one cycle of stimulus, queue the model's expected outputs, step past the edge.
  task automatic cyc(input logic [7:0] r, input logic e);
    bit found;
    req    = r;
    arb_en = e;
    if (!m_grant) begin
      if (e && r != 8'h00) begin
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
          if (!found && r[(m_ptr + k) % 8]) begin
            found = 1'b1;
            m_idx = 3'((m_ptr + k) % 8);
          end
        end
        m_valid = 1'b1;
        m_hold  = 1;
        m_grant = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
    end else if (!r[m_idx] || m_hold == MAXH) begin
      m_valid = 1'b0;
      m_ptr   = (int'(m_idx) + 1) % 8;
      m_hold  = 0;
      m_grant = 1'b0;
    end else begin
      m_hold = m_hold + 1;
    end
    sb.push_back({m_valid, m_idx});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] exp;
    model_reset();
    #12;
    n_vec++;
    if (gnt_valid !== 1'b0 || gnt_idx !== 3'd0) begin
      n_err++;
      $display("FAIL reset_state: got valid=%b idx=%0d, need valid=0 idx=0", gnt_valid, gnt_idx);
    end
    rst_n = 1'b1;
    cyc(8'h00, 1'b0);
    cyc(8'h04, 1'b1);
    cyc(8'h04, 1'b1);
    for (int i = 0; i < 3; i++) begin
      exp = sb.pop_front();
      n_vec++;
      if ({gnt_valid, gnt_idx} !== exp && i == 2) begin
        n_err++;
        $display("FAIL reset_pre_grant: got %h, need %h", {gnt_valid, gnt_idx}, exp);
      end
    end
    #3 rst_n = 1'b0;
    #1;
    n_vec++;
    if (gnt_valid !== 1'b0 || gnt_idx !== 3'd0) begin
      n_err++;
      $display("FAIL reset_async: got valid=%b idx=%0d, need valid=0 idx=0", gnt_valid, gnt_idx);
    end
    model_reset();
    #2 rst_n = 1'b1;
    cyc(8'h04, 1'b1);
    exp = sb.pop_front();
    n_vec++;
    if ({gnt_valid, gnt_idx} !== exp || {gnt_valid, gnt_idx} !== 4'hA) begin
      n_err++;
      $display("FAIL reset_regrant: got %h, need %h", {gnt_valid, gnt_idx}, 4'hA);
    end
    cyc(8'h00, 1'b1);
    exp = sb.pop_front();
  endtask

  task automatic test_rotation();
    logic [3:0] exp;
    logic [7:0] drop;
    cyc(8'h80, 1'b1);
    cyc(8'h00, 1'b1);
    exp = sb.pop_front();
    exp = sb.pop_front();
    for (int k = 0; k < 9; k++) begin
      drop = 8'hFF & ~(8'h01 << (k % 8));
      for (int c = 0; c < 3; c++) begin
        cyc((c == 2) ? drop : 8'hFF, 1'b1);
        exp = sb.pop_front();
        n_vec++;
        if ({gnt_valid, gnt_idx} !== exp ||
            gnt_valid !== (c != 2) || (c != 2 && gnt_idx !== 3'(k % 8))) begin
          n_err++;
          $display("FAIL rotation k=%0d c=%0d: got valid=%b idx=%0d, need %h",
                   k, c, gnt_valid, gnt_idx, exp);
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [3:0] exp;
    logic [7:0] rv[5] = '{8'h20, 8'h00, 8'h21, 8'h20, 8'h21};
    logic [3:0] want[5] = '{4'hD, 4'h5, 4'h8, 4'h0, 4'hD};
    for (int i = 0; i < 5; i++) begin
      cyc(rv[i], 1'b1);
      exp = sb.pop_front();
      n_vec++;
      if ({gnt_valid, gnt_idx} !== exp || {gnt_valid, gnt_idx} !== want[i]) begin
        n_err++;
        $display("FAIL wrap step %0d: got %h, need %h", i, {gnt_valid, gnt_idx}, want[i]);
      end
    end
    cyc(8'h00, 1'b1);
    exp = sb.pop_front();
  endtask

  task automatic test_hold_limit();
    logic [3:0] exp;
    logic [3:0] want[6] = '{4'hA, 4'hA, 4'hA, 4'hA, 4'h2, 4'hB};
    cyc(8'h02, 1'b1);
    cyc(8'h00, 1'b1);
    exp = sb.pop_front();
    exp = sb.pop_front();
    for (int i = 0; i < 6; i++) begin
      cyc(8'h0C, 1'b1);
      exp = sb.pop_front();
      n_vec++;
      if ({gnt_valid, gnt_idx} !== exp || {gnt_valid, gnt_idx} !== want[i]) begin
        n_err++;
        $display("FAIL hold_limit cycle %0d: got %h, need %h", i, {gnt_valid, gnt_idx}, want[i]);
      end
    end
    cyc(8'h00, 1'b1);
    exp = sb.pop_front();
  endtask

  task automatic test_enable();
    logic [3:0] exp;
    logic [7:0] rv[8]   = '{8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h00, 8'h10};
    logic       ev[8]   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       want[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      cyc(rv[i], ev[i]);
      exp = sb.pop_front();
      n_vec++;
      if ({gnt_valid, gnt_idx} !== exp || gnt_valid !== want[i] ||
          (want[i] && gnt_idx !== 3'd4)) begin
        n_err++;
        $display("FAIL enable step %0d: got valid=%b idx=%0d, need valid=%b idx=4",
                 i, gnt_valid, gnt_idx, want[i]);
      end
    end
  endtask

  task automatic test_decoder();
    logic [3:0] exp;
    logic [7:0] dec;
    logic [7:0] want;
    for (int i = 0; i < 11; i++) begin
      cyc(8'h80, 1'b1);
      exp  = sb.pop_front();
      dec  = gnt_valid ? (8'h01 << gnt_idx) : 8'h00;
      want = ((i % 5) == 4) ? 8'h00 : 8'h80;
      n_vec++;
      if ({gnt_valid, gnt_idx} !== exp || dec !== want) begin
        n_err++;
        $display("FAIL decoder cycle %0d: got sel=%h, need %h", i, dec, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_wrap();
    test_hold_limit();
    test_enable();
    test_decoder();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
